// File: rtl/clk_gen_pkg.sv
// clk_gen_pkg: shared state encoding and divide/phase helpers for the
// programmable multi-channel clock generator.
`default_nettype none

package clk_gen_pkg;

  typedef enum logic [2:0] {
    S_RESET  = 3'd0,
    S_HOLD   = 3'd1,
    S_ALIGN  = 3'd2,
    S_RUN    = 3'd3,
    S_LOCKED = 3'd4
  } state_t;

  // Divide ratios below 2 cannot produce a square wave, so they are clamped.
  function automatic int unsigned sanitise_div(input int unsigned div);
    return (div < 2) ? 2 : div;
  endfunction

  function automatic int unsigned sanitise_phase(input int unsigned phase,
                                                 input int unsigned n);
    return (phase > n - 1) ? n - 1 : phase;
  endfunction

  // Odd ratios spend the extra cycle high.
  function automatic int unsigned hi_thresh(input int unsigned n);
    return (n + 1) >> 1;
  endfunction

  function automatic int lock_cnt_w(input int lock_cycles);
    return $clog2(lock_cycles + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/clk_gen_channel.sv
// clk_gen_channel: one divided-clock channel with shadow N/P registers,
// a phase-loaded counter and registered outclk/tick.
`default_nettype none

module clk_gen_channel
  import clk_gen_pkg::*;
#(
  parameter int DIV_W     = 8,
  parameter int DEF_DIV   = 4,
  parameter int DEF_PHASE = 0
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_align,
  input  logic             i_run,
  input  logic             i_wr_en,
  input  logic [DIV_W-1:0] i_div,
  input  logic [DIV_W-1:0] i_phase,
  output logic             o_outclk,
  output logic             o_tick
);

  localparam logic [DIV_W-1:0] C_RST_N = DIV_W'(sanitise_div(DEF_DIV));
  localparam logic [DIV_W-1:0] C_RST_P =
    DIV_W'(sanitise_phase(DEF_PHASE, sanitise_div(DEF_DIV)));

  logic [DIV_W-1:0] r_n;
  logic [DIV_W-1:0] r_p;
  logic [DIV_W-1:0] r_cnt;
  logic             r_outclk;
  logic             r_tick;

  logic [DIV_W-1:0] w_n_wr;
  logic [DIV_W-1:0] w_p_wr;
  logic [DIV_W-1:0] w_load;
  logic [DIV_W:0]   w_hi;
  logic [DIV_W-1:0] w_cnt_nxt;
  logic             w_active;

  assign w_n_wr   = DIV_W'(sanitise_div(32'(i_div)));
  assign w_p_wr   = DIV_W'(sanitise_phase(32'(i_phase), 32'(w_n_wr)));
  // Starting at N-P makes the first wrap to zero land P cycles later.
  assign w_load   = (r_p == '0) ? '0 : r_n - r_p;
  assign w_hi     = (DIV_W+1)'(hi_thresh(32'(r_n)));
  assign w_active = i_align | i_run;

  always_comb begin
    w_cnt_nxt = '0;
    if (i_align) begin
      w_cnt_nxt = w_load;
    end else if (i_run) begin
      w_cnt_nxt = (r_cnt == r_n - 1'b1) ? '0 : r_cnt + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_n      <= C_RST_N;
      r_p      <= C_RST_P;
      r_cnt    <= '0;
      r_outclk <= 1'b0;
      r_tick   <= 1'b0;
    end else begin
      if (i_wr_en) begin
        r_n <= w_n_wr;
        r_p <= w_p_wr;
      end
      r_cnt    <= w_cnt_nxt;
      r_tick   <= w_active && (w_cnt_nxt == '0);
      r_outclk <= w_active && ({1'b0, w_cnt_nxt} < w_hi);
    end
  end

  assign o_outclk = r_outclk;
  assign o_tick   = r_tick;

endmodule

`default_nettype wire

// File: rtl/clk_gen_multi.sv
// clk_gen_multi: NUM_CH programmable divided clocks from one reference,
// sharing a single align/run/lock sequencer and a config write port.
`default_nettype none

module clk_gen_multi
  import clk_gen_pkg::*;
#(
  parameter int NUM_CH      = 2,
  parameter int DIV_W       = 8,
  parameter int LOCK_CYCLES = 16,
  parameter int DEF_DIV     = 4,
  parameter int DEF_PHASE   = 0
) (
  input  logic                                       refclk,
  input  logic                                       rst,
  input  logic                                       en,
  input  logic                                       cfg_valid,
  output logic                                       cfg_ready,
  input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] cfg_ch,
  input  logic [DIV_W-1:0]                           cfg_div,
  input  logic [DIV_W-1:0]                           cfg_phase,
  output logic [NUM_CH-1:0]                          outclk,
  output logic [NUM_CH-1:0]                          tick,
  output logic                                       locked
);

  localparam int             CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int             LCW         = lock_cnt_w(LOCK_CYCLES);
  localparam logic [CH_W:0]  C_NUM_CH    = (CH_W+1)'(NUM_CH);
  localparam logic [LCW-1:0] C_LOCK_LAST = LCW'(LOCK_CYCLES - 1);

  state_t         r_state;
  state_t         w_next;
  logic [LCW-1:0] r_lock_cnt;
  logic           r_locked;

  logic w_cfg_ready;
  logic w_accept;
  logic w_ch_ok;
  logic w_realign;
  logic w_align;
  logic w_run;

  assign w_cfg_ready = (r_state != S_RESET) && (r_state != S_ALIGN);
  assign w_accept    = cfg_valid && w_cfg_ready;
  assign w_ch_ok     = {1'b0, cfg_ch} < C_NUM_CH;
  assign w_realign   = w_accept && w_ch_ok;
  // Gating with en makes the channels clear on the same edge that enters HOLD.
  assign w_align     = (r_state == S_ALIGN) && en;
  assign w_run       = ((r_state == S_RUN) || (r_state == S_LOCKED)) && en;

  always_comb begin
    w_next = r_state;
    if (r_state == S_RESET) begin
      w_next = en ? S_ALIGN : S_HOLD;
    end else if (!en) begin
      w_next = S_HOLD;
    end else if (w_realign) begin
      w_next = S_ALIGN;
    end else begin
      case (r_state)
        S_HOLD:  w_next = S_ALIGN;
        S_ALIGN: w_next = S_RUN;
        S_RUN:   if (r_lock_cnt == C_LOCK_LAST) w_next = S_LOCKED;
        default: w_next = r_state;
      endcase
    end
  end

  always_ff @(posedge refclk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_RESET;
      r_lock_cnt <= '0;
      r_locked   <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_lock_cnt <= ((r_state == S_RUN) && (w_next == S_RUN)) ? r_lock_cnt + 1'b1 : '0;
      r_locked   <= (w_next == S_LOCKED);
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic w_wr_en;
    assign w_wr_en = w_realign && (cfg_ch == CH_W'(g));

    clk_gen_channel #(
      .DIV_W     (DIV_W),
      .DEF_DIV   (DEF_DIV),
      .DEF_PHASE (DEF_PHASE)
    ) u_ch (
      .i_clk    (refclk),
      .i_rst_n  (rst),
      .i_align  (w_align),
      .i_run    (w_run),
      .i_wr_en  (w_wr_en),
      .i_div    (cfg_div),
      .i_phase  (cfg_phase),
      .o_outclk (outclk[g]),
      .o_tick   (tick[g])
    );
  end

  assign cfg_ready = w_cfg_ready;
  assign locked    = r_locked;

endmodule

`default_nettype wire

// File: tb/tb_clk_gen_multi.sv
// tb_clk_gen_multi: directed self-checking bench for clk_gen_multi with
// three channels so an out-of-range channel index is representable.
`default_nettype none

module tb_clk_gen_multi;

  localparam int NUM_CH = 3;

  logic        refclk = 1'b0;
  logic        rst;
  logic        en;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [1:0]  cfg_ch;
  logic [7:0]  cfg_div;
  logic [7:0]  cfg_phase;
  logic [NUM_CH-1:0] outclk;
  logic [NUM_CH-1:0] tick;
  logic        locked;

  int checks   = 0;
  int failures = 0;
  int k_since  = 0;
  int exp_n [NUM_CH];
  int exp_p [NUM_CH];

  clk_gen_multi #(
    .NUM_CH      (NUM_CH),
    .DIV_W       (8),
    .LOCK_CYCLES (16),
    .DEF_DIV     (4),
    .DEF_PHASE   (0)
  ) dut (
    .refclk    (refclk),
    .rst       (rst),
    .en        (en),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_ch    (cfg_ch),
    .cfg_div   (cfg_div),
    .cfg_phase (cfg_phase),
    .outclk    (outclk),
    .tick      (tick),
    .locked    (locked)
  );

  always #5 refclk = ~refclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge refclk);
    #1;
  endtask

  task automatic set_defaults();
    for (int c = 0; c < NUM_CH; c++) begin
      exp_n[c] = 4;
      exp_p[c] = 0;
    end
  endtask

  // Expected outputs k cycles after the align cycle: cnt = (L + k - 1) mod N.
  task automatic model_chk(input string tag);
    logic [NUM_CH-1:0] eo;
    logic [NUM_CH-1:0] et;
    for (int c = 0; c < NUM_CH; c++) begin
      int l;
      int cnt;
      l     = (exp_p[c] == 0) ? 0 : exp_n[c] - exp_p[c];
      cnt   = (l + k_since - 1) % exp_n[c];
      eo[c] = (cnt < (exp_n[c] + 1) / 2);
      et[c] = (cnt == 0);
    end
    chk($sformatf("%s_k%0d_outclk", tag, k_since), 32'(outclk), 32'(eo));
    chk($sformatf("%s_k%0d_tick", tag, k_since), 32'(tick), 32'(et));
    chk($sformatf("%s_k%0d_locked", tag, k_since), 32'(locked), 32'(k_since >= 17));
  endtask

  task automatic run_cycles(input string tag, input int n);
    repeat (n) begin
      step();
      k_since++;
      model_chk(tag);
    end
  endtask

  task automatic align_chk(input string tag);
    chk({tag, "_align_ready"}, 32'(cfg_ready), 32'd0);
    chk({tag, "_align_locked"}, 32'(locked), 32'd0);
    k_since = 0;
  endtask

  task automatic write_cfg(input logic [1:0] ch, input logic [7:0] div, input logic [7:0] ph);
    cfg_valid = 1'b1;
    cfg_ch    = ch;
    cfg_div   = div;
    cfg_phase = ph;
    step();
    cfg_valid = 1'b0;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_outclk"}, 32'(outclk), 32'd0);
    chk({tag, "_tick"}, 32'(tick), 32'd0);
    chk({tag, "_locked"}, 32'(locked), 32'd0);
  endtask

  initial begin
    rst       = 1'b0;
    en        = 1'b1;
    cfg_valid = 1'b0;
    cfg_ch    = '0;
    cfg_div   = '0;
    cfg_phase = '0;
    set_defaults();

    #3;
    chk_quiet("reset");
    chk("reset_ready", 32'(cfg_ready), 32'd0);

    @(posedge refclk);
    #1;
    rst = 1'b1;
    #1;
    chk("reset_state_ready", 32'(cfg_ready), 32'd0);
    step();
    align_chk("boot");
    run_cycles("default", 20);
    chk("run_ready", 32'(cfg_ready), 32'd1);

    write_cfg(2'd1, 8'd4, 8'd1);
    align_chk("ch1_phase");
    exp_p[1] = 1;
    run_cycles("ch1_phase", 20);

    write_cfg(2'd0, 8'd5, 8'd0);
    align_chk("div5");
    exp_n[0] = 5;
    run_cycles("div5", 12);

    write_cfg(2'd0, 8'd0, 8'd0);
    align_chk("div0");
    exp_n[0] = 2;
    run_cycles("div0", 8);

    write_cfg(2'd0, 8'd4, 8'd7);
    align_chk("phase_clamp");
    exp_n[0] = 4;
    exp_p[0] = 3;
    run_cycles("phase_clamp", 20);

    // Out-of-range channel: pattern and lock must continue undisturbed.
    write_cfg(2'd3, 8'd9, 8'd2);
    k_since++;
    model_chk("bad_ch");
    chk("bad_ch_ready", 32'(cfg_ready), 32'd1);
    run_cycles("bad_ch_after", 8);

    en = 1'b0;
    step();
    chk_quiet("en_fall");
    chk("hold_ready", 32'(cfg_ready), 32'd1);
    repeat (3) step();
    chk_quiet("hold");
    en = 1'b1;
    step();
    align_chk("reenable");
    run_cycles("reenable", 18);

    en        = 1'b0;
    cfg_valid = 1'b1;
    cfg_ch    = 2'd2;
    cfg_div   = 8'd3;
    cfg_phase = 8'd0;
    step();
    cfg_valid = 1'b0;
    chk_quiet("en_fall_wr");
    step();
    en = 1'b1;
    step();
    align_chk("en_fall_wr");
    exp_n[2] = 3;
    run_cycles("en_fall_wr", 18);

    #2;
    rst = 1'b0;
    #1;
    chk_quiet("async_rst");
    chk("async_rst_ready", 32'(cfg_ready), 32'd0);
    #2;
    rst = 1'b1;
    step();
    align_chk("post_rst");
    set_defaults();
    run_cycles("post_rst", 18);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
